// File: rtl/mul4_share_arb_if.sv
// Bundles the requester and response signals of mul4_share_arb.
// Parameters: NUM_REQ requesters, IDW-bit response tag.
// master: the client side. It drives the requests and resp_ready, and observes the rest.
// slave : the arbiter side (mul4_share_arb).
interface mul4_share_arb_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = 3
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [4*NUM_REQ-1:0] req_a;
  logic [4*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [7:0]           resp_p;
  logic [IDW-1:0]       resp_id;
  logic                 busy;
  logic [15:0]          op_count;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_p, resp_id, busy, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_p, resp_id, busy, op_count
  );
endinterface

// File: rtl/mul4_share_arb.sv
// mul4_share_arb: shares one 4x4 array multiplier among NUM_REQ valid/ready requesters.
// Ports:
//   clk  - rising-edge clock.
//   rst  - synchronous, active-high reset.
//   bus  - mul4_share_arb_if.slave. It carries the requests (valid/a/b/ready),
//          the response (valid/ready/p/id), busy, and the 16-bit op_count.
// Build option: MUL4_ARB_FIXED_PRI_EN selects fixed priority (the lowest index wins).
//   The default build uses round-robin arbitration.

// Combinational 4x4 unsigned array multiplier: shifted AND rows, summed.
module four_bitarrmul (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [7:0] pp [4];

  for (genvar i = 0; i < 4; i++) begin : g_pp
    assign pp[i] = {4'b0000, a & {4{b[i]}}} << i;
  end

  assign p = pp[0] + pp[1] + pp[2] + pp[3];
endmodule

module mul4_share_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = 3
) (
  input  logic            clk,
  input  logic            rst,
  mul4_share_arb_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_RESP} state_t;

  state_t         state_q, state_d;
  logic           any_valid;
  logic [IDW-1:0] grant_idx;
  logic [3:0]     sel_a, sel_b;
  logic [3:0]     op_a_q, op_b_q;
  logic [IDW-1:0] id_q;
  logic [7:0]     mul_p;
  logic [7:0]     resp_p_q;
  logic [IDW-1:0] resp_id_q;
  logic           resp_valid_q;
  logic [15:0]    op_count_q;
  logic           busy_q;

`ifdef MUL4_ARB_FIXED_PRI_EN
  // Fixed priority: the descending scan lets the lowest set index win.
  always_comb begin
    grant_idx = '0;
    any_valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        grant_idx = IDW'(i);
        any_valid = 1'b1;
      end
    end
  end
`else
  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [2*NUM_REQ-1:0] dbl_valid;
  logic [NUM_REQ-1:0]   rot_valid;
  logic [PW:0]          win_sum;

  // Rotate the valids so that rr_ptr maps to bit 0. The first set bit is then the winner.
  assign dbl_valid = {bus.req_valid, bus.req_valid};
  assign rot_valid = NUM_REQ'(dbl_valid >> rr_ptr_q);

  always_comb begin
    grant_idx = '0;
    any_valid = 1'b0;
    win_sum   = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (rot_valid[off]) begin
        win_sum = {1'b0, rr_ptr_q} + (PW+1)'(off);
        if (win_sum >= (PW+1)'(NUM_REQ)) begin
          win_sum = win_sum - (PW+1)'(NUM_REQ);
        end
        any_valid = 1'b1;
      end
    end
    grant_idx = IDW'(win_sum);
  end

  // After a grant, the pointer moves to the index just past the winner.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == S_IDLE && any_valid) begin
      if (grant_idx == IDW'(NUM_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = PW'(grant_idx) + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  // Select the operands of the winning requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == grant_idx) begin
        sel_a = bus.req_a[4*i +: 4];
        sel_b = bus.req_b[4*i +: 4];
      end
    end
  end

  four_bitarrmul u_mul (
    .a (op_a_q),
    .b (op_b_q),
    .p (mul_p)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_valid) state_d = S_MUL;
      S_MUL:   state_d = S_RESP;
      S_RESP:  if (bus.resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: the grant is combinational and is offered only in IDLE, outside reset.
  always_comb begin
    bus.req_ready = '0;
    if (state_q == S_IDLE && !rst && any_valid) begin
      bus.req_ready = NUM_REQ'(1) << grant_idx;
    end
  end

  // Datapath: latch the operands, register the product, and count completions.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q       <= '0;
      op_b_q       <= '0;
      id_q         <= '0;
      resp_p_q     <= '0;
      resp_id_q    <= '0;
      resp_valid_q <= 1'b0;
      op_count_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      busy_q <= (state_d != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (any_valid) begin
            op_a_q <= sel_a;
            op_b_q <= sel_b;
            id_q   <= grant_idx;
          end
        end
        S_MUL: begin
          resp_p_q     <= mul_p;
          resp_id_q    <= id_q;
          resp_valid_q <= 1'b1;
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            op_count_q   <= op_count_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_p     = resp_p_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.busy       = busy_q;
  assign bus.op_count   = op_count_q;
endmodule

// File: tb/tb_mul4_share_arb.sv
// Directed testbench for mul4_share_arb with NUM_REQ=4 and IDW=3.
module tb_mul4_share_arb;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mul4_share_arb_if #(.NUM_REQ(4), .IDW(3)) bus ();

  mul4_share_arb #(.NUM_REQ(4), .IDW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at a negedge, with reset released and inputs idle.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One full operation with resp_ready high. Starts and ends at a negedge in IDLE.
  task automatic do_op(input string tag, input logic [3:0] vld, input logic [15:0] a,
                       input logic [15:0] b, input int g, input logic [7:0] p);
    bus.req_valid  = vld;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.resp_ready = 1'b1;
    #1;
    chk({tag, " grant"}, 32'(bus.req_ready), 32'(1) << g);
    @(negedge clk);
    chk({tag, " mul_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, " mul_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, " mul_valid"}, 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    chk({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({tag, " resp_p"}, 32'(bus.resp_p), 32'(p));
    chk({tag, " resp_id"}, 32'(bus.resp_id), 32'(g));
    @(negedge clk);
    chk({tag, " done_valid"}, 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;

    // Reset state. req_ready must stay low while rst is high.
    @(negedge clk);
    @(negedge clk);
    bus.req_valid = 4'b0001;
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_p", 32'(bus.resp_p), 32'd0);
    chk("rst_id", 32'(bus.resp_id), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_cnt", 32'(bus.op_count), 32'd0);

    // Single request with the largest product: 15 * 15 = 0xE1.
    do_reset();
    do_op("single", 4'b0001, 16'h000F, 16'h000F, 0, 8'hE1);
    chk("single_cnt", 32'(bus.op_count), 32'd1);
    chk("single_busy", 32'(bus.busy), 32'd0);

    // Fairness: requester i drives a = i+1 and b = 2, with all four held valid.
    do_reset();
    for (int k = 0; k < 5; k++) begin
`ifdef MUL4_ARB_FIXED_PRI_EN
      do_op("fair", 4'b1111, 16'h4321, 16'h2222, 0, 8'h02);
`else
      do_op("fair", 4'b1111, 16'h4321, 16'h2222, k % 4, 8'(2 * (k % 4 + 1)));
`endif
    end
    chk("fair_cnt", 32'(bus.op_count), 32'd5);

    // Back-pressure: requester 0 is served first while 1 and 2 stay pending.
    do_reset();
    bus.req_valid  = 4'b0111;
    bus.req_a      = 16'h0A73;
    bus.req_b      = 16'h0B52;
    bus.resp_ready = 1'b0;
    #1;
    chk("bp_grant0", 32'(bus.req_ready), 32'b0001);
    @(negedge clk);
    bus.req_valid = 4'b0110;
    @(negedge clk);
    chk("bp_valid", 32'(bus.resp_valid), 32'd1);
    chk("bp_p", 32'(bus.resp_p), 32'h06);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("bp_hold_p", 32'(bus.resp_p), 32'h06);
      chk("bp_hold_id", 32'(bus.resp_id), 32'd0);
      chk("bp_hold_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_hold_busy", 32'(bus.busy), 32'd1);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_busy", 32'(bus.busy), 32'd0);
    chk("bp_idle_valid", 32'(bus.resp_valid), 32'd0);
    chk("bp_idle_cnt", 32'(bus.op_count), 32'd1);
    chk("bp_grant1", 32'(bus.req_ready), 32'b0010);
    do_op("bp_next", 4'b0110, 16'h0A73, 16'h0B52, 1, 8'h23);

    // Exhaustive product sweep from requester 3.
    do_reset();
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op("sweep", 4'b1000, {4'(a), 12'h000}, {4'(b), 12'h000}, 3, 8'(a * b));
      end
    end
    chk("sweep_cnt", 32'(bus.op_count), 32'd256);

    // Reset during MUL: the pending response is discarded and is not counted.
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_a     = 16'h0003;
    bus.req_b     = 16'h0003;
    @(negedge clk);
    chk("mr_busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_valid", 32'(bus.resp_valid), 32'd0);
    chk("mr_p", 32'(bus.resp_p), 32'd0);
    chk("mr_cnt", 32'(bus.op_count), 32'd0);
    chk("mr_busy", 32'(bus.busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mr_no_stale", 32'(bus.resp_valid), 32'd0);
    end

    // Counter wrap: preload 0xFFFF, then complete one more operation.
    do_reset();
    dut.op_count_q = 16'hFFFF;
    #1;
    chk("wrap_pre", 32'(bus.op_count), 32'hFFFF);
    do_op("wrap", 4'b0100, 16'h0500, 16'h0300, 2, 8'h0F);
    chk("wrap_cnt", 32'(bus.op_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
